// File: rtl/sram_chip_emu.sv
`default_nettype none
// ============================================================================
// sram_chip_emu : device-side emulator of a 16-bit async SRAM on block RAM.
// Optional build macro SRAM_EMU_VIOL_EN adds the sticky protocol-violation flag.
// Revision: 1.0
// ============================================================================
module sram_chip_emu #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] ad,
  input  logic        we_n,
  input  logic        oe_n,
  input  logic        ce_n,
  input  logic        ub_n,
  input  logic        lb_n,
  inout  wire  [15:0] dio,
  output logic        busy,
  output logic        viol
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_RD_DRV  = 2'd3;
  localparam logic [3:0] C_LAT_LOAD = 4'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              wr_ub_n_q, wr_lb_n_q;
  logic [15:0]       rd_data_q;
  logic [7:0]        mem_lo [DEPTH];
  logic [7:0]        mem_hi [DEPTH];

  logic              w_wr_req, w_rd_req;
  logic              w_latch, w_commit, w_drive;
  logic [ADDR_W-1:0] w_addr;

  assign w_addr   = ad[ADDR_W-1:0];
  assign w_wr_req = ~ce_n & ~we_n;
  assign w_rd_req = ~ce_n & ~oe_n & we_n;

  generate
    if (ADDR_W < 18) begin : g_unused_ad
      logic w_unused_ad;
      assign w_unused_ad = ^ad[17:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A write strobe wins over any read in progress, mirroring the real chip.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_wr_req) begin
          state_d = ST_WR;
        end else if (w_rd_req) begin
          state_d = ST_RD_WAIT;
          cnt_d   = C_LAT_LOAD;
        end
      end
      ST_WR: begin
        if (ce_n || we_n) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (w_wr_req)            state_d = ST_WR;
        else if (ce_n || oe_n)   state_d = ST_IDLE;
        else if (cnt_q == 4'd0)  state_d = ST_RD_DRV;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      ST_RD_DRV: begin
        if (w_wr_req)            state_d = ST_WR;
        else if (ce_n || oe_n)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    w_latch  = (state_d == ST_WR);
    w_commit = (state_q == ST_WR) && (state_d != ST_WR);
    w_drive  = (state_q == ST_RD_DRV) && w_rd_req;
  end

  // Only cycles with the strobe still asserted are captured, so the commit
  // uses the last values seen before the controller released the write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_ub_n_q <= 1'b1;
      wr_lb_n_q <= 1'b1;
    end else if (w_latch) begin
      wr_addr_q <= w_addr;
      wr_data_q <= dio;
      wr_ub_n_q <= ub_n;
      wr_lb_n_q <= lb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !wr_lb_n_q) mem_lo[wr_addr_q] <= wr_data_q[7:0];
    if (w_commit && !wr_ub_n_q) mem_hi[wr_addr_q] <= wr_data_q[15:8];
    rd_data_q <= {mem_hi[w_addr], mem_lo[w_addr]};
  end

  // Drive gating is combinational so the bus frees in the strobe's own cycle.
  assign dio[7:0]  = (w_drive && !lb_n) ? rd_data_q[7:0]  : 8'hzz;
  assign dio[15:8] = (w_drive && !ub_n) ? rd_data_q[15:8] : 8'hzz;

`ifdef SRAM_EMU_VIOL_EN
  logic viol_q;
  logic w_viol_evt;

  assign w_viol_evt = (~ce_n & ~we_n & ~oe_n)
                    | ((state_q == ST_WR) && w_latch && (w_addr != wr_addr_q))
                    | (w_commit && wr_ub_n_q && wr_lb_n_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        viol_q <= 1'b0;
    else if (w_viol_evt) viol_q <= 1'b1;
  end

  assign viol = viol_q;
`else
  assign viol = 1'b0;
`endif

endmodule
`default_nettype wire
